mux7_rr_collector: RTL and testbench



---
 rtl/mux7_pkg.sv | 16 +
 rtl/rr_arbiter7.sv | 35 +++
 rtl/mux7_rr_collector.sv | 85 ++++++++
 tb/tb_mux7_rr_collector.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mux7_pkg.sv
// Shared constants and index helper for the 7-channel round-robin collector.
package mux7_pkg;

  localparam int unsigned NCH       = 7;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned WIDTH_DEF = 13;

  // Last-grant pointer at reset: channel 0 is searched first.
  localparam logic [SEL_W-1:0] PTR_RST = 3'd6;

  // Modulo-7 successor; index 7 is never a valid channel.
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] i);
    return (i == 3'd6) ? 3'd0 : SEL_W'(i + 3'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter7.sv
// Combinational 7-way round-robin arbiter: first requester after ptr, modulo 7.
module rr_arbiter7
  import mux7_pkg::*;
(
  input  logic [NCH-1:0]   req,
  input  logic [SEL_W-1:0] ptr,
  input  logic             en,
  output logic [NCH-1:0]   gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             any
);

  logic             found;
  logic [SEL_W-1:0] cand;

  // Walk ptr+1 .. ptr+7 (wrapping 6 -> 0) and keep the first hit.
  always_comb begin
    found      = 1'b0;
    cand       = ptr;
    gnt_idx    = '0;
    gnt_onehot = '0;
    any        = |req;
    for (int k = 0; k < int'(NCH); k++) begin
      cand = next_idx(cand);
      if (!found && req[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (en && found) begin
      gnt_onehot = NCH'(1) << gnt_idx;
    end
  end

endmodule

// File: rtl/mux7_rr_collector.sv
// Merges seven valid/ready channels into one registered, channel-tagged stream.
module mux7_rr_collector
  import mux7_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SEL_W-1:0]     out_sel
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_sel_q,   out_sel_d;
  logic [SEL_W-1:0] ptr_q,       ptr_d;

  logic             load_c;
  logic             any_c;
  logic [SEL_W-1:0] gnt_idx_c;
  logic [NCH-1:0]   gnt_onehot_c;
  logic [WIDTH-1:0] chan_data_c [NCH];

  // Output register is free when empty or being drained this cycle.
  assign load_c = !out_valid_q || out_ready;

  rr_arbiter7 u_arb (
    .req        (in_valid),
    .ptr        (ptr_q),
    .en         (load_c && rst_n),
    .gnt_onehot (gnt_onehot_c),
    .gnt_idx    (gnt_idx_c),
    .any        (any_c)
  );

  assign in_ready = gnt_onehot_c;

  always_comb begin
    for (int i = 0; i < int'(NCH); i++) begin
      chan_data_c[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Next-state: transfer, drain, or hold on stall.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    ptr_d       = ptr_q;
    if (load_c) begin
      if (any_c) begin
        out_valid_d = 1'b1;
        out_data_d  = chan_data_c[gnt_idx_c];
        out_sel_d   = gnt_idx_c;
        ptr_d       = gnt_idx_c;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      ptr_q       <= PTR_RST;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux7_rr_collector.sv
// Directed bench for mux7_rr_collector against a modulo-7 round-robin reference model.
module tb_mux7_rr_collector;

  localparam int W = 13;

  logic           clk;
  logic           rst_n;
  logic [6:0]     in_valid;
  logic [7*W-1:0] in_data;
  logic [6:0]     in_ready;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [2:0]     out_sel;

  int checks;
  int errors;

  // Reference model state
  bit         m_valid;
  int         m_data;
  int         m_sel;
  int         m_ptr;

  mux7_rr_collector #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int chan(input int i);
    logic [W-1:0] v;
    v = in_data[i*W +: W];
    return int'(v);
  endfunction

  function automatic void set_chan(input int i, input int v);
    in_data[i*W +: W] = W'(v);
  endfunction

  // Winner of the round-robin search starting after m_ptr, or -1 when idle.
  function automatic int model_grant();
    for (int k = 1; k <= 7; k++) begin
      int c;
      c = (m_ptr + k) % 7;
      if (in_valid[c]) return c;
    end
    return -1;
  endfunction

  function automatic int model_ready();
    int g;
    g = model_grant();
    if (!rst_n || (m_valid && !out_ready) || g < 0) return 0;
    return 1 << g;
  endfunction

  // One clock: check the handshake strobe, advance model, check registered outputs.
  task automatic cycle();
    int g;
    #1;
    chk("in_ready", int'(in_ready), model_ready());
    @(posedge clk);
    g = model_grant();
    if (!rst_n) begin
      m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 6;
    end else if (!m_valid || out_ready) begin
      if (g >= 0) begin
        m_valid = 1; m_data = chan(g); m_sel = g; m_ptr = g;
      end else begin
        m_valid = 0;
      end
    end
    #1;
    chk("out_valid", int'(out_valid), int'(m_valid));
    chk("out_sel", int'(out_sel), m_sel);
    chk("out_data", int'(out_data), m_data);
    chk("sel_range", int'(out_sel != 3'd7), 1);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_seq [9];
    checks = 0; errors = 0;
    m_valid = 0; m_data = 0; m_sel = 0; m_ptr = 6;
    rst_n = 1'b0; in_valid = 7'h7F; out_ready = 1'b1; in_data = '0;
    for (int i = 0; i < 7; i++) set_chan(i, 100 + i);

    // Reset with every channel requesting
    do_reset(2);
    chk("rst_valid_lit", int'(out_valid), 0);
    chk("rst_sel_lit", int'(out_sel), 0);
    chk("rst_data_lit", int'(out_data), 0);

    // First grant after reset is channel 0
    cycle();
    chk("first_grant_lit", int'(out_sel), 0);
    chk("first_data_lit", int'(out_data), 100);

    // Single channel 2
    in_valid = 7'b0000100;
    set_chan(2, 13'b1010101010101);
    #1;
    chk("single_ready_lit", int'(in_ready), 7'b0000100);
    cycle();
    chk("single_sel_lit", int'(out_sel), 2);
    chk("single_data_lit", int'(out_data), 13'h1555);
    chk("single_valid_lit", int'(out_valid), 1);

    // Round-robin with wrap, fresh pointer
    in_valid = 7'h00;
    cycle();
    do_reset(1);
    for (int i = 0; i < 7; i++) set_chan(i, i);
    in_valid = 7'h7F;
    exp_seq = '{0, 1, 2, 3, 4, 5, 6, 0, 1};
    for (int i = 0; i < 9; i++) begin
      cycle();
      chk("rr_sel_lit", int'(out_sel), exp_seq[i]);
      chk("rr_data_lit", int'(out_data), exp_seq[i]);
    end

    // Backpressure with channels 1 and 5
    do_reset(1);
    set_chan(1, 13'h0AAA); set_chan(5, 13'h1234);
    in_valid = 7'b0100010;
    cycle();
    chk("bp_first_lit", int'(out_sel), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_hold_lit", int'(out_sel), 1);
      chk("bp_ready_lit", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    cycle();
    chk("bp_next5_lit", int'(out_sel), 5);
    chk("bp_data5_lit", int'(out_data), 13'h1234);
    cycle();
    chk("bp_then1_lit", int'(out_sel), 1);

    // Sparse traffic and drain
    in_valid = 7'h00;
    cycle();
    in_valid = 7'b1000000;
    set_chan(6, 13'h1FFF);
    cycle();
    chk("sp_valid_lit", int'(out_valid), 1);
    chk("sp_sel_lit", int'(out_sel), 6);
    in_valid = 7'h00;
    cycle();
    chk("drain_valid_lit", int'(out_valid), 0);
    chk("drain_sel_lit", int'(out_sel), 6);
    chk("drain_data_lit", int'(out_data), 13'h1FFF);
    in_valid = 7'b0000001;
    set_chan(0, 13'h0042);
    cycle();
    chk("wrap_grant_lit", int'(out_sel), 0);
    chk("wrap_data_lit", int'(out_data), 13'h0042);

    // Reset while a word is stalled
    in_valid = 7'b0001000;
    cycle();
    out_ready = 1'b0;
    in_valid = 7'h7F;
    cycle();
    chk("midrst_pre_lit", int'(out_sel), 3);
    do_reset(1);
    chk("midrst_valid_lit", int'(out_valid), 0);
    chk("midrst_sel_lit", int'(out_sel), 0);
    out_ready = 1'b1;
    cycle();
    chk("midrst_grant_lit", int'(out_sel), 0);

    // Mixed request and backpressure patterns, model-checked
    for (int i = 0; i < 60; i++) begin
      in_valid  = 7'($urandom_range(0, 127));
      out_ready = 1'($urandom_range(0, 3) != 0);
      for (int c = 0; c < 7; c++) set_chan(c, int'($urandom_range(0, 8191)));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
